// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating direction counters
// Define BTP_STATS_EN to build the resolved-branch and misprediction counters.
module branch_target_predictor #(
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   output logic        pred_hit_o,
   output logic        pred_taken_o,
   output logic [31:0] pred_next_pc_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i,
   input  logic [31:0] upd_pred_next_pc_i,
   output logic        mispredict_o,
   output logic [31:0] redirect_pc_o,
   output logic [31:0] stat_branches_o,
   output logic [31:0] stat_mispred_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
   localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

   logic [ENTRIES-1:0]            valid_q,  valid_d;
   logic [ENTRIES-1:0][TAG_W-1:0] tag_q,    tag_d;
   logic [ENTRIES-1:0][31:0]      target_q, target_d;
   logic [ENTRIES-1:0][CNT_W-1:0] cnt_q,    cnt_d;

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic [31:0]      upd_fallthru;
   logic [31:0]      actual_next;

   // Lookup reads only the registered table, so a same-cycle update is not visible yet.
   always_comb begin
      lk_idx         = pc_i[IDX_W+1:2];
      lk_tag         = pc_i[31:IDX_W+2];
      lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_hit_o     = lk_hit;
      pred_taken_o   = lk_hit && cnt_q[lk_idx][CNT_W-1];
      pred_next_pc_o = pred_taken_o ? target_q[lk_idx] : (pc_i + 32'd4);
   end

   always_comb begin
      upd_idx       = upd_pc_i[IDX_W+1:2];
      upd_tag       = upd_pc_i[31:IDX_W+2];
      upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      upd_fallthru  = upd_pc_i + 32'd4;
      actual_next   = upd_taken_i ? upd_target_i : upd_fallthru;
      redirect_pc_o = (upd_valid_i && upd_taken_i) ? upd_target_i : upd_fallthru;
      mispredict_o  = upd_valid_i && (actual_next != upd_pred_next_pc_i);
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (upd_valid_i) begin
         if (upd_hit) begin
            if (upd_taken_i) begin
               if (cnt_q[upd_idx] != CNT_MAX) begin
                  cnt_d[upd_idx] = cnt_q[upd_idx] + 1'b1;
               end
               target_d[upd_idx] = upd_target_i;
            end else if (cnt_q[upd_idx] != '0) begin
               cnt_d[upd_idx] = cnt_q[upd_idx] - 1'b1;
            end
         end else if (upd_taken_i) begin
            // Taken miss replaces whatever lives at this index, starting weakly taken.
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target_i;
            cnt_d[upd_idx]    = CNT_WEAK_T;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         cnt_q   <= {ENTRIES{CNT_WEAK_NT}};
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BTP_STATS_EN
   logic [31:0] stat_br_q, stat_br_d;
   logic [31:0] stat_mp_q, stat_mp_d;

   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (upd_valid_i && (stat_br_q != 32'hFFFF_FFFF)) begin
         stat_br_d = stat_br_q + 32'd1;
      end
      if (mispredict_o && (stat_mp_q != 32'hFFFF_FFFF)) begin
         stat_mp_d = stat_mp_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         stat_br_q <= stat_br_d;
         stat_mp_q <= stat_mp_d;
      end
   end

   assign stat_branches_o = stat_br_q;
   assign stat_mispred_o  = stat_mp_q;
`else
   assign stat_branches_o = 32'd0;
   assign stat_mispred_o  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - scoreboard bench for branch_target_predictor
// Reference model keeps per-index table state; expectations queued and checked by a monitor.
module tb_branch_target_predictor;

   localparam int ENTRIES = 16;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int CNT_WT  = 1 << (CNT_W - 1);

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] pc_i;
   logic        pred_hit_o, pred_taken_o;
   logic [31:0] pred_next_pc_o;
   logic        upd_valid_i, upd_taken_i;
   logic [31:0] upd_pc_i, upd_target_i, upd_pred_next_pc_i;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o, stat_branches_o, stat_mispred_o;

   always #5 clk = ~clk;

   branch_target_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
      .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_next_pc_o(pred_next_pc_o),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
      .upd_target_i(upd_target_i), .upd_pred_next_pc_i(upd_pred_next_pc_i),
      .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
      .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
   );

   typedef struct {
      logic        hit;
      logic        taken;
      logic [31:0] next;
      logic        misp;
      logic [31:0] redir;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   bit          m_valid [ENTRIES];
   logic [31:0] m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_cnt   [ENTRIES];
   logic [31:0] m_sb, m_sm;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 32'd4) % ENTRIES);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc / (32'd4 * ENTRIES);
   endfunction

   function automatic logic [31:0] model_pred(input logic [31:0] pc);
      int i;
      i = idx_of(pc);
      if (m_valid[i] && m_tag[i] == tag_of(pc) && m_cnt[i] >= CNT_WT) return m_tgt[i];
      return pc + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_cnt[i]   = CNT_WT - 1;
      end
      m_sb = 0;
      m_sm = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, queue expected outputs, then advance the model past the edge.
   task automatic cyc(input logic rst, input logic [31:0] pc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                      input logic [31:0] upred);
      exp_t        e;
      int          i;
      logic [31:0] actual;
      logic        mp;
      rst_i = rst; pc_i = pc; upd_valid_i = uv; upd_pc_i = upc;
      upd_taken_i = ut; upd_target_i = utgt; upd_pred_next_pc_i = upred;
      i       = idx_of(pc);
      e.hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
      e.taken = e.hit && (m_cnt[i] >= CNT_WT);
      e.next  = e.taken ? m_tgt[i] : pc + 32'd4;
      actual  = ut ? utgt : upc + 32'd4;
      mp      = uv && (actual != upred);
      e.misp  = mp;
      e.redir = uv ? actual : upc + 32'd4;
`ifdef BTP_STATS_EN
      e.sb = m_sb;
      e.sm = m_sm;
`else
      e.sb = 0;
      e.sm = 0;
`endif
      q.push_back(e);
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else if (uv) begin
         i = idx_of(upc);
         if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
            if (ut) begin
               m_cnt[i] = (m_cnt[i] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
               m_tgt[i] = utgt;
            end else begin
               m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end
         end else if (ut) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upc);
            m_tgt[i]   = utgt;
            m_cnt[i]   = CNT_WT;
         end
         if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 1;
         if (mp && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
      end
   endtask

   task automatic look(input logic [31:0] pc);
      cyc(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic [31:0] upred);
      cyc(1'b0, pc, 1'b1, upc, ut, utgt, upred);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("pred_hit",     32'(pred_hit_o),   32'(e.hit));
         chk("pred_taken",   32'(pred_taken_o), 32'(e.taken));
         chk("pred_next_pc", pred_next_pc_o,    e.next);
         chk("mispredict",   32'(mispredict_o), 32'(e.misp));
         chk("redirect_pc",  redirect_pc_o,     e.redir);
         chk("stat_branches", stat_branches_o,  e.sb);
         chk("stat_mispred",  stat_mispred_o,   e.sm);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] p, u, t, pr;
      logic        tk;
      int          wait_cnt;
      model_reset();
      rst_i = 1'b1; pc_i = 0; upd_valid_i = 0; upd_pc_i = 0;
      upd_taken_i = 0; upd_target_i = 0; upd_pred_next_pc_i = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;

      look(32'h40);
      upd(32'h40, 32'h40, 1'b1, 32'h80, 32'h44);
      look(32'h40);
      look(32'h43);
      upd(32'h40, 32'h40, 1'b1, 32'h80, 32'h80);
      upd(32'h40, 32'h40, 1'b1, 32'h80, 32'h80);
      upd(32'h40, 32'h40, 1'b0, 32'h80, 32'h80);
      look(32'h40);
      upd(32'h40, 32'h40, 1'b0, 32'h80, 32'h80);
      look(32'h40);
      upd(32'h40, 32'h40, 1'b0, 32'h80, 32'h44);
      upd(32'h40, 32'h40, 1'b0, 32'h80, 32'h44);
      look(32'h40);
      upd(32'h40, 32'h40, 1'b1, 32'h90, 32'h44);
      upd(32'h40, 32'h40, 1'b1, 32'h94, 32'h90);
      look(32'h40);

      upd(32'h80, 32'h80, 1'b1, 32'h200, 32'h84);
      look(32'h40);
      look(32'h80);
      upd(32'h100, 32'h100, 1'b0, 32'h300, 32'h104);
      look(32'h80);
      look(32'h100);

      upd(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h10, 32'h0);
      upd(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h10, 32'h0);
      look(32'hFFFF_FFFC);
      look(32'hFFFF_FFF8);

      cyc(1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h80, 32'h44);
      look(32'h40);
      look(32'h80);
      look(32'hFFFF_FFFC);

      for (int n = 0; n < 10; n++) begin
         u = 32'h1000 + 32'(n) * 32'h4;
         upd(u, u, (n % 2) == 0, 32'h2000, (n < 3) ? 32'h0 : model_pred(u) + ((n % 2) == 0 ? 32'h0 : 32'h0));
      end
      look(32'h0);

      for (int n = 0; n < 600; n++) begin
         p  = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         u  = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2);
         t  = 32'h100 + (32'($urandom_range(0, 3)) << 4);
         tk = ($urandom_range(0, 9) < 6);
         pr = ($urandom_range(0, 9) < 7) ? model_pred(u) : t;
         cyc(($urandom_range(0, 99) == 0), p, ($urandom_range(0, 3) != 0), u, tk, t, pr);
      end
      look(32'h0);

      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
